// File: rtl/bcd_step_counter_pkg.sv
// Shared BCD constants and the single-digit step function used by the BCD
// step counter and future multi-digit blocks.
package bcd_step_counter_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;
    localparam logic       DIR_UP  = 1'b1;
    localparam logic       DIR_DN  = 1'b0;

    typedef struct packed {
        logic       carry;
        logic [3:0] digit;
    } bcd_step_t;

    // One BCD step in the given direction; carry marks the 9->0 / 0->9 wrap.
    function automatic bcd_step_t bcd_next(input logic [3:0] digit, input logic dir);
        bcd_step_t res;
        res.carry = 1'b0;
        res.digit = digit;
        if (dir == DIR_UP) begin
            if (digit >= BCD_MAX) begin
                res.digit = BCD_MIN;
                res.carry = 1'b1;
            end else begin
                res.digit = digit + 4'd1;
            end
        end else begin
            if (digit == BCD_MIN) begin
                res.digit = BCD_MAX;
                res.carry = 1'b1;
            end else begin
                res.digit = digit - 4'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_step_counter_sync.sv
// Two-flop synchroniser followed by a rising-edge pulse generator, suitable
// for any raw board push-button.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s2_d;

    // Synchroniser chain plus one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= i_in;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign o_pulse = r_s2 & ~r_s2_d;

endmodule

// File: rtl/bcd_step_counter.sv
// Single BCD digit counter advanced by a prescaled auto-run tick or a manual
// push-button step, with parallel load and a sticky invalid-load flag.
module bcd_step_counter
    import bcd_step_counter_pkg::*;
#(
    parameter int TICK_DIV = 50,
    parameter int CNT_W    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       dir,
    input  logic       step_btn,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       carry,
    output logic       load_err
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_presc;
    logic [3:0]       r_digit;
    logic             r_carry;
    logic             r_load_err;
    logic             w_tick;
    logic             w_step;
    logic             w_adv;
    bcd_step_t        w_next;

    sync_edge_detect u_step_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_in    (step_btn),
        .o_pulse (w_step)
    );

    assign w_tick = run & (r_presc == TICK_LAST);
    assign w_adv  = w_tick | w_step;
    assign w_next = bcd_next(r_digit, dir);

    // Prescaler: free-runs 0..TICK_DIV-1 while run is high, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (!run) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Digit register: load beats advance, and an invalid load leaves the digit alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit    <= BCD_MIN;
            r_carry    <= 1'b0;
            r_load_err <= 1'b0;
        end else if (load) begin
            r_carry <= 1'b0;
            if (load_val <= BCD_MAX) begin
                r_digit    <= load_val;
                r_load_err <= 1'b0;
            end else begin
                r_digit    <= r_digit;
                r_load_err <= 1'b1;
            end
        end else if (w_adv) begin
            r_digit    <= w_next.digit;
            r_carry    <= w_next.carry;
            r_load_err <= r_load_err;
        end else begin
            r_digit    <= r_digit;
            r_carry    <= 1'b0;
            r_load_err <= r_load_err;
        end
    end

    assign A        = r_digit[3];
    assign B        = r_digit[2];
    assign C        = r_digit[1];
    assign D        = r_digit[0];
    assign carry    = r_carry;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Self-checking bench for bcd_step_counter: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the digit.
module tb_bcd_step_counter;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       dir;
    logic       step_btn;
    logic       load;
    logic [3:0] load_val;
    logic       A, B, C, D;
    logic       carry;
    logic       load_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_digit;
    bit m_carry;
    bit m_err;
    int m_runcnt;
    bit h1, h2, h3;

    bcd_step_counter #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .dir      (dir),
        .step_btn (step_btn),
        .load     (load),
        .load_val (load_val),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .carry    (carry),
        .load_err (load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dig();
        return int'({A, B, C, D});
    endfunction

    // One rising edge: update the model from the inputs held since the last
    // falling edge, then return at the falling edge for checking/driving.
    task automatic clk_edge();
        bit tk, st;
        @(posedge clk);
        if (!rst_n) begin
            m_digit = 0; m_carry = 0; m_err = 0; m_runcnt = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            tk = run && ((m_runcnt % TD) == TD - 1);
            m_runcnt = run ? m_runcnt + 1 : 0;
            st = h2 && !h3;
            h3 = h2; h2 = h1; h1 = step_btn;
            if (load) begin
                m_carry = 0;
                if (load_val <= 4'd9) begin
                    m_digit = int'(load_val);
                    m_err = 0;
                end else begin
                    m_err = 1;
                end
            end else if (tk || st) begin
                m_carry = dir ? (m_digit == 9) : (m_digit == 0);
                m_digit = (m_digit + (dir ? 1 : 9)) % 10;
            end else begin
                m_carry = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; dir = 1'b1; step_btn = 1'b0;
        load = 1'b1; load_val = 4'd5;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            n_cmp++;
            if ({A, B, C, D, carry, load_err} !== 6'b000000) begin
                n_fail++;
                $display("FAIL reset_hold edge%0d: got digit=%0d carry=%b err=%b, want 0/0/0", i, dig(), carry, load_err);
            end
        end
        rst_n = 1'b1; run = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            n_cmp++;
            if (dig() !== 0 || carry !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release cyc%0d: got digit=%0d carry=%b, want 0/0", i, dig(), carry);
            end
        end
    endtask

    task automatic test_auto_up();
        int ncarry;
        ncarry = 0;
        rst_n = 1'b0; run = 1'b0; load = 1'b0; step_btn = 1'b0;
        clk_edge();
        rst_n = 1'b1; run = 1'b1; dir = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            clk_edge();
            if (carry === 1'b1) ncarry++;
            n_cmp++;
            if (dig() !== (n / TD) % 10 || carry !== ((n == 40) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL auto_up edge%0d: got digit=%0d carry=%b, want %0d/%b", n, dig(), carry, (n / TD) % 10, (n == 40));
            end
        end
        n_cmp++;
        if (ncarry != 1) begin
            n_fail++;
            $display("FAIL auto_up_carry_count: got %0d, want 1", ncarry);
        end
    endtask

    task automatic test_manual_down();
        run = 1'b0; dir = 1'b0; load = 1'b0; step_btn = 1'b0;
        clk_edge();
        step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            clk_edge();
            n_cmp++;
            if (dig() !== ((i >= 3) ? 9 : 0) || carry !== ((i == 3) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL manual_hold edge%0d: got digit=%0d carry=%b, want %0d/%b", i, dig(), carry, (i >= 3) ? 9 : 0, (i == 3));
            end
        end
        step_btn = 1'b0;
        repeat (4) clk_edge();
        step_btn = 1'b1;
        repeat (4) clk_edge();
        n_cmp++;
        if (dig() !== 8 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL manual_repress: got digit=%0d carry=%b, want 8/0", dig(), carry);
        end
        step_btn = 1'b0;
        repeat (3) clk_edge();
    endtask

    task automatic test_load();
        logic [3:0] vals [3];
        int         exp_d [3];
        logic       exp_e [3];
        vals[0] = 4'd7;  exp_d[0] = 7; exp_e[0] = 1'b0;
        vals[1] = 4'd12; exp_d[1] = 7; exp_e[1] = 1'b1;
        vals[2] = 4'd3;  exp_d[2] = 3; exp_e[2] = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load = 1'b1; load_val = vals[i];
            clk_edge();
            load = 1'b0;
            clk_edge();
            n_cmp++;
            if (dig() !== exp_d[i] || load_err !== exp_e[i] || carry !== 1'b0) begin
                n_fail++;
                $display("FAIL load_%0d: got digit=%0d err=%b carry=%b, want %0d/%b/0", vals[i], dig(), load_err, carry, exp_d[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_collision();
        run = 1'b0; dir = 1'b1; step_btn = 1'b0;
        load = 1'b1; load_val = 4'd4;
        clk_edge();
        load = 1'b0; run = 1'b1;
        clk_edge();
        step_btn = 1'b1;
        clk_edge();
        clk_edge();
        n_cmp++;
        if (dig() !== 4) begin
            n_fail++;
            $display("FAIL collide_pre: got digit=%0d, want 4", dig());
        end
        clk_edge();
        n_cmp++;
        if (dig() !== 5) begin
            n_fail++;
            $display("FAIL collide_tick_step: got digit=%0d, want 5", dig());
        end
        step_btn = 1'b0;
        repeat (3) clk_edge();
        load = 1'b1; load_val = 4'd2;
        clk_edge();
        load = 1'b0;
        n_cmp++;
        if (dig() !== 2 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_load_tick: got digit=%0d carry=%b, want 2/0", dig(), carry);
        end
        clk_edge();
        n_cmp++;
        if (dig() !== 2) begin
            n_fail++;
            $display("FAIL collide_load_after: got digit=%0d, want 2", dig());
        end
    endtask

    task automatic test_reset_mid();
        run = 1'b0; dir = 1'b1; step_btn = 1'b0;
        load = 1'b1; load_val = 4'd9;
        clk_edge();
        load = 1'b0; run = 1'b1;
        repeat (TD - 1) clk_edge();
        rst_n = 1'b0;
        clk_edge();
        rst_n = 1'b1; run = 1'b0;
        n_cmp++;
        if (dig() !== 0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got digit=%0d carry=%b, want 0/0", dig(), carry);
        end
        clk_edge();
        n_cmp++;
        if (carry !== 1'b0 || dig() !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got digit=%0d carry=%b, want 0/0", dig(), carry);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            dir      = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            clk_edge();
            n_cmp++;
            if (dig() !== m_digit || carry !== m_carry || load_err !== m_err || dig() > 9) begin
                n_fail++;
                $display("FAIL random cyc%0d: got digit=%0d carry=%b err=%b, want %0d/%b/%b", i, dig(), carry, load_err, m_digit, m_carry, m_err);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; dir = 1'b1; step_btn = 1'b0;
        load = 1'b0; load_val = 4'd0;
        @(negedge clk);
        test_reset();
        test_auto_up();
        test_manual_down();
        test_load();
        test_collision();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_step_counter.md
Name: bcd_step_counter

Overview:
- Upstream source for the team's seg_display decoder. Produces the 4-bit BCD digit on outputs A,B,C,D (A = MSB), which connect directly to the decoder inputs of the same names.
- The digit advances from one of two sources:
  - an internal prescaled tick (auto-run mode);
  - a synchronised, edge-detected push-button (manual step).
- The digit can be loaded in parallel. Load values above 9 are rejected and flagged.

Parameters:
- TICK_DIV, 50, clock cycles per auto-run step (must be ≥2).
- CNT_W, 6, prescaler counter width. Must satisfy 2^CNT_W > TICK_DIV-1.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  synchronous, active-low reset
- run  input  1  1 = auto-advance on prescaler tick
- dir  input  1  1 = count up, 0 = count down
- step_btn  input  1  raw asynchronous push-button, active-high
- load  input  1  parallel load strobe, synchronous
- load_val  input  4  value to load
- A  output  1  digit bit 3 (MSB)
- B  output  1  digit bit 2
- C  output  1  digit bit 1
- D  output  1  digit bit 0 (LSB)
- carry  output  1  one-cycle pulse on wrap (9→0 up, 0→9 down)
- load_err  output  1  sticky flag: last load value was invalid

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low (rst_n sampled on clk rising edge).
  - rst_n=0 at an edge forces: digit=0 (A=B=C=D=0), carry=0, load_err=0, prescaler=0, both sync flops=0, edge-detect history=0.
  - Reset overrides every other input, including mid-step and mid-load.
- All outputs are registered. None is combinational from inputs.
- Prescaler:
  - While run=1, it counts 0..TICK_DIV-1 and wraps.
  - tick=1 for the single cycle in which prescaler==TICK_DIV-1.
  - While run=0, the prescaler is held at 0 and no tick occurs.
  - After run rises at edge k, the first tick-driven digit update occurs at edge k+TICK_DIV.
- Manual step:
  - step_btn passes through a 2-flop synchroniser (s1, s2), then a rising-edge detect: step = s2 & ~s2_d.
  - If step_btn rises before edge k (s1 captures it at k, s2 at k+1), the digit updates at edge k+2.
  - Holding the button produces exactly one step. There is no debounce; that is the board's responsibility.
- Advance:
  - adv = tick | step.
  - If tick and step coincide, the digit advances once, not twice.
  - Up: 0→1…8→9, 9→0 with carry=1.
  - Down: 9→8…1→0, 0→9 with carry=1.
  - dir is sampled in the same cycle as adv.
- carry:
  - High for exactly the one cycle following the wrapping edge.
  - 0 otherwise, including on load.
- Load (highest priority after reset):
  - load=1 with load_val≤9: digit=load_val at the next edge, load_err cleared, any coincident adv discarded, carry=0.
  - load=1 with load_val≥10: digit unchanged, load_err=1, any coincident adv also discarded.
  - load_err stays set until the next valid load or reset.
  - load does not disturb the prescaler or synchroniser.
- Invariant: the digit never holds a value above 9 in any cycle.

Decomposition:
- Shared package/header constants:
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - DIR_UP = 1'b1
  - DIR_DN = 1'b0
- These constants are reused by the seg_display bench and by future multi-digit blocks.
- One natural sub-module: sync_edge_detect (2-flop synchroniser plus rising-edge pulse, clk/rst_n, in → pulse). It is reusable for every board button.
- The prescaler and digit register stay inline.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with run=1, load=1, load_val=5 → A..D=0000, carry=0, load_err=0 throughout. Release: digit stays 0 until the first tick or step.
- Auto-run up: TICK_DIV=4, run=1, dir=1 from reset → digit increments every 4 cycles, 0,1,…,9,0. carry pulses exactly 1 cycle at the 9→0 wrap. Total wrap after 40 cycles.
- Manual down with hold: run=0, dir=0, digit=0; step_btn high for 10 cycles → one step only. Digit becomes 9 two edges after s1 captures the button, carry=1 for one cycle. Release and re-press → digit 8.
- Load valid/invalid: load 4'd7 → digit 7, load_err=0. Load 4'd12 → digit stays 7, load_err=1. Load 4'd3 → digit 3, load_err=0.
- Collisions:
  - tick and step in the same cycle with digit=4, dir=1 → digit 5, not 6.
  - load 4'd2 in the same cycle as a tick → digit 2, carry=0.
- Reset mid-operation: run=1 with digit at 9 and prescaler at TICK_DIV-1, assert rst_n=0 at that edge → digit 0, no carry pulse emitted.
